add16_op_sequencer: RTL and testbench
=====================================

# add16_op_sequencer

Sequential operand/result stage wrapped around the team's combinational 16-bit adder (ripple or 4-bit-CLA variant; external, selected at integration). Accepts 16- or 32-bit add/subtract requests over a valid/ready handshake and drives the adder's A/B/Cin. It waits a programmable settle time, captures S/Cout, and chains a second pass for 32-bit operations. Returns a 32-bit result with carry, signed-overflow and zero flags over a valid/ready handshake.

## Interface
- SETTLE_CYCLES, 2, cycles the adder inputs are held before S/Cout is sampled; legal range 1..15; must cover the worst-case adder delay.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- in_a  in  32  operand A (narrow ops use [15:0]).
- in_b  in  32  operand B (narrow ops use [15:0]).
- in_sub  in  1  1 = A − B, 0 = A + B.
- in_wide  in  1  1 = 32-bit op (two passes), 0 = 16-bit op.
- add_a  out  16  to adder A.
- add_b  out  16  to adder B (inverted when subtracting).
- add_cin  out  1  to adder Cin.
- add_s  in  16  from adder S.
- add_cout  in  1  from adder Cout.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_sum  out  32  result; [31:16] = 0 for narrow ops.
- out_carry  out  1  final carry-out (for subtract, 1 = no borrow).
- out_ovf  out  1  two's-complement signed overflow at the active width.
- out_zero  out  1  result is zero at the active width.

## Operation
- States: IDLE, LO, HI, DONE. in_ready = 1 only in IDLE. out_valid = 1 only in DONE.
- Operands, in_sub and in_wide are registered at accept. After accept, the upstream may change its inputs freely.
- Let b' = in_sub ? ~in_b : in_b.
- IDLE → LO on in_valid && in_ready:
  - add_a = a[15:0], add_b = b'[15:0], add_cin = in_sub.
  - Settle counter loads SETTLE_CYCLES.
- LO: counter decrements each cycle. On its last cycle (counter == 1), sum[15:0] ← add_s and c_lo ← add_cout. Next state:
  - Narrow: → DONE.
  - Wide: → HI, with add_a = a[31:16], add_b = b'[31:16], add_cin = c_lo; counter reloads.
- HI: same countdown. On the last cycle, sum[31:16] ← add_s and carry ← add_cout; → DONE.
- Flags computed on entry to DONE. Let msb = 15 (narrow) or 31 (wide).
  - out_ovf = (a[msb] == b'[msb]) && (sum[msb] != a[msb]).
  - out_zero = (sum over the active width == 0).
  - out_carry = final pass's cout.
- DONE → IDLE on out_ready. The result and flags hold stable while out_ready = 0.
- add_a/add_b/add_cin change only at accept and at LO→HI. They hold their values otherwise, including in DONE and IDLE.
- in_valid while not in IDLE is ignored (not accepted, not queued).

## Timing
- Reset values: in_ready = 1; out_valid = 0; out_sum, out_carry, out_ovf, out_zero = 0; add_a, add_b, add_cin = 0; state = IDLE.
- Accept edge = cycle 0.
  - Narrow: LO occupies cycles 1..S (S = SETTLE_CYCLES); out_valid is high from cycle S+1.
  - Wide: HI occupies cycles S+1..2S; out_valid is high from cycle 2S+1.
- Adder inputs are registered outputs. add_s is sampled no earlier than S full cycles after add_a/add_b/add_cin change.
- With out_ready held high, out_valid is high for exactly one cycle. in_ready rises the following cycle.
- Back-to-back period: narrow S+2 cycles; wide 2S+2 cycles.
- rst_n low at any point, including mid-LO/HI or in DONE: the operation is aborted with no result. All outputs take reset values asynchronously. First accept is possible on the first rising edge after release.

## Test plan
- Reset mid-op: assert rst_n low during HI of a wide op → out_valid 0 and add_* 0 immediately; in_ready = 1 after release; the next request completes normally.
- Narrow add, S=2: A=0x24D7, B=0x0414 → out_sum 0x000028EB, carry 0, ovf 0, zero 0; out_valid first high at cycle 3.
- Narrow add with carry: A=0xFDE8, B=0x0414 → out_sum 0x000001FC, carry 1, ovf 0. Narrow sub: A=0x8000, B=0x0001 → add_b 0xFFFE, add_cin 1; out_sum 0x00007FFF, carry 1, ovf 1.
- Wide add, S=2: A=0x0000FFFF, B=0x00000001 → add_cin = 1 during HI; out_sum 0x00010000, carry 0, zero 0; out_valid at cycle 5. Wide sub: 0x12345678 − 0x12345678 → out_sum 0, zero 1, carry 1, ovf 0.
- Backpressure: hold out_ready low 5 cycles in DONE → out_valid and result stable; in_ready 0; an in_valid pulse in that window is not accepted. out_ready high → IDLE next cycle.
- SETTLE_CYCLES=1 and 15: latency exactly S+1 (narrow) and 2S+1 (wide). Use an adder model whose outputs are X until S cycles after its inputs change; the captured value must never be X.

Source files
------------

// File: rtl/add16_op_sequencer.sv
// Operand/result sequencer around an external combinational 16-bit adder.
// Handles 16-bit ops in one pass and 32-bit ops in two passes, with a programmable settle time.
module add16_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    input  logic        in_wide,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_cin,
    input  logic [15:0] add_s,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_carry,
    output logic        out_ovf,
    output logic        out_zero
);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    localparam logic [3:0] CntLoad = 4'(SETTLE_CYCLES);

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] bp_q, bp_d;
    logic        wide_q, wide_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] sum_q, sum_d;
    logic        carry_q, carry_d;
    logic        ovf_q, ovf_d;
    logic        zero_q, zero_d;
    logic [15:0] add_a_q, add_a_d;
    logic [15:0] add_b_q, add_b_d;
    logic        add_cin_q, add_cin_d;

    logic [31:0] b_in;
    logic        last;
    logic [31:0] sum_wide;

    // Subtraction is A + ~B + 1; the inverted operand is kept for the overflow check.
    assign b_in     = in_sub ? ~in_b : in_b;
    assign last     = (cnt_q == 4'd1);
    assign sum_wide = {add_s, sum_q[15:0]};

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        bp_d      = bp_q;
        wide_d    = wide_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d       = in_a;
                    bp_d      = b_in;
                    wide_d    = in_wide;
                    add_a_d   = in_a[15:0];
                    add_b_d   = b_in[15:0];
                    add_cin_d = in_sub;
                    cnt_d     = CntLoad;
                    state_d   = StLo;
                end
            end
            StLo: begin
                if (!last) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (wide_q) begin
                    // Low-half carry feeds straight into the high pass.
                    sum_d[15:0] = add_s;
                    add_a_d     = a_q[31:16];
                    add_b_d     = bp_q[31:16];
                    add_cin_d   = add_cout;
                    cnt_d       = CntLoad;
                    state_d     = StHi;
                end else begin
                    sum_d   = {16'h0000, add_s};
                    carry_d = add_cout;
                    ovf_d   = (a_q[15] == bp_q[15]) && (add_s[15] != a_q[15]);
                    zero_d  = (add_s == 16'h0000);
                    state_d = StDone;
                end
            end
            StHi: begin
                if (!last) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    sum_d   = sum_wide;
                    carry_d = add_cout;
                    ovf_d   = (a_q[31] == bp_q[31]) && (add_s[15] != a_q[31]);
                    zero_d  = (sum_wide == 32'h0000_0000);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            bp_q      <= '0;
            wide_q    <= 1'b0;
            cnt_q     <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            bp_q      <= bp_d;
            wide_q    <= wide_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_sum   = sum_q;
    assign out_carry = carry_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;

endmodule

// File: tb/tb_add16_op_sequencer.sv
// Directed bench for add16_op_sequencer: three instances (settle 2, 1, 15), each driving an
// adder model whose outputs stay X until its inputs have been stable long enough.
module tb_add16_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic [2:0]  in_valid;
    logic [31:0] in_a, in_b;
    logic        in_sub, in_wide, out_ready;
    logic [2:0]  in_ready, add_cin, add_cout, out_valid, out_carry, out_ovf, out_zero;
    logic [15:0] add_a [3];
    logic [15:0] add_b [3];
    logic [15:0] add_s [3];
    logic [31:0] out_sum [3];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a, b;
        logic        sub, wide;
        logic [31:0] sum;
        logic        c, o, z;
        logic [15:0] xa, xb;
        logic        xcin;
    } vec_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned S = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        logic [32:0] prev = '0;
        int          age  = 0;
        logic [16:0] r;

        // Outputs become valid just before the S-th edge after an input change.
        always @(posedge clk) begin
            #1;
            if ({add_a[g], add_b[g], add_cin[g]} !== prev) begin
                prev = {add_a[g], add_b[g], add_cin[g]};
                age  = 0;
            end else if (age < 1000) begin
                age++;
            end
        end

        assign r = (age >= int'(S) - 1) ?
                   ({1'b0, add_a[g]} + {1'b0, add_b[g]} + {16'h0000, add_cin[g]}) : 'x;
        assign add_s[g]    = r[15:0];
        assign add_cout[g] = r[16];

        add16_op_sequencer #(.SETTLE_CYCLES(S)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_a      (in_a),
            .in_b      (in_b),
            .in_sub    (in_sub),
            .in_wide   (in_wide),
            .add_a     (add_a[g]),
            .add_b     (add_b[g]),
            .add_cin   (add_cin[g]),
            .add_s     (add_s[g]),
            .add_cout  (add_cout[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .out_sum   (out_sum[g]),
            .out_carry (out_carry[g]),
            .out_ovf   (out_ovf[g]),
            .out_zero  (out_zero[g])
        );
    end

    // Issue one request from idle, scramble the inputs after accept, and return the cycle
    // index (1 = cycle after the accept edge) at which out_valid is first seen.
    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic wide, output int lat);
        in_a = a; in_b = b; in_sub = sub; in_wide = wide;
        in_valid[idx] = 1'b1;
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
        in_a = 32'hDEAD_BEEF; in_b = 32'h5A5A_A5A5; in_sub = ~sub; in_wide = ~wide;
        lat = 1;
        while (!out_valid[idx] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (in_ready[i] !== 1'b1) begin
                bad++; $display("FAIL reset_in_ready[%0d] got %b want 1", i, in_ready[i]);
            end
            total++;
            if (out_valid[i] !== 1'b0) begin
                bad++; $display("FAIL reset_out_valid[%0d] got %b want 0", i, out_valid[i]);
            end
            total++;
            if ({out_sum[i], out_carry[i], out_ovf[i], out_zero[i]} !== 35'h0) begin
                bad++; $display("FAIL reset_result[%0d] got sum %h c%b o%b z%b want 0", i,
                                out_sum[i], out_carry[i], out_ovf[i], out_zero[i]);
            end
            total++;
            if ({add_a[i], add_b[i], add_cin[i]} !== 33'h0) begin
                bad++; $display("FAIL reset_adder[%0d] got a %h b %h cin %b want 0", i,
                                add_a[i], add_b[i], add_cin[i]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready[0] !== 1'b1) begin
            bad++; $display("FAIL post_reset_in_ready got %b want 1", in_ready[0]);
        end
    endtask

    task automatic test_narrow;
        vec_t v[4];
        int   lat;
        v[0] = '{32'h0000_24D7, 32'h0000_0414, 1'b0, 1'b0, 32'h0000_28EB, 1'b0, 1'b0, 1'b0,
                 16'h24D7, 16'h0414, 1'b0};
        v[1] = '{32'h0000_FDE8, 32'h0000_0414, 1'b0, 1'b0, 32'h0000_01FC, 1'b1, 1'b0, 1'b0,
                 16'hFDE8, 16'h0414, 1'b0};
        v[2] = '{32'h0000_8000, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_7FFF, 1'b1, 1'b1, 1'b0,
                 16'h8000, 16'hFFFE, 1'b1};
        v[3] = '{32'hFFFF_1234, 32'h0000_1234, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1,
                 16'h1234, 16'hEDCB, 1'b1};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_op(0, v[i].a, v[i].b, v[i].sub, v[i].wide, lat);
            total++;
            if (lat != 3) begin
                bad++; $display("FAIL narrow%0d_latency got %0d want 3", i, lat);
            end
            total++;
            if (out_sum[0] !== v[i].sum) begin
                bad++; $display("FAIL narrow%0d_sum got %h want %h", i, out_sum[0], v[i].sum);
            end
            total++;
            if ({out_carry[0], out_ovf[0], out_zero[0]} !== {v[i].c, v[i].o, v[i].z}) begin
                bad++; $display("FAIL narrow%0d_flags got c%b o%b z%b want c%b o%b z%b", i,
                                out_carry[0], out_ovf[0], out_zero[0], v[i].c, v[i].o, v[i].z);
            end
            total++;
            if ({add_a[0], add_b[0], add_cin[0]} !== {v[i].xa, v[i].xb, v[i].xcin}) begin
                bad++; $display("FAIL narrow%0d_adder got a %h b %h cin %b want %h %h %b", i,
                                add_a[0], add_b[0], add_cin[0], v[i].xa, v[i].xb, v[i].xcin);
            end
            ack();
        end
    endtask

    task automatic test_wide;
        vec_t v[4];
        int   lat;
        v[0] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0,
                 16'h0000, 16'h0000, 1'b1};
        v[1] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1,
                 16'h1234, 16'hEDCB, 1'b1};
        v[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0,
                 16'h7FFF, 16'h0000, 1'b1};
        v[3] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0,
                 16'h0000, 16'hFFFF, 1'b0};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_op(0, v[i].a, v[i].b, v[i].sub, v[i].wide, lat);
            total++;
            if (lat != 5) begin
                bad++; $display("FAIL wide%0d_latency got %0d want 5", i, lat);
            end
            total++;
            if (out_sum[0] !== v[i].sum) begin
                bad++; $display("FAIL wide%0d_sum got %h want %h", i, out_sum[0], v[i].sum);
            end
            total++;
            if ({out_carry[0], out_ovf[0], out_zero[0]} !== {v[i].c, v[i].o, v[i].z}) begin
                bad++; $display("FAIL wide%0d_flags got c%b o%b z%b want c%b o%b z%b", i,
                                out_carry[0], out_ovf[0], out_zero[0], v[i].c, v[i].o, v[i].z);
            end
            total++;
            if ({add_a[0], add_b[0], add_cin[0]} !== {v[i].xa, v[i].xb, v[i].xcin}) begin
                bad++; $display("FAIL wide%0d_hi_adder got a %h b %h cin %b want %h %h %b", i,
                                add_a[0], add_b[0], add_cin[0], v[i].xa, v[i].xb, v[i].xcin);
            end
            ack();
        end
    endtask

    task automatic test_back_to_back;
        for (int w = 0; w < 2; w++) begin
            int acc[$];
            int nv;
            int per;
            nv  = 0;
            per = (w != 0) ? 6 : 4;
            out_ready = 1'b1;
            in_a = 32'h1; in_b = 32'h2; in_sub = 1'b0; in_wide = (w != 0);
            in_valid[0] = 1'b1;
            for (int k = 0; k < 14; k++) begin
                if (in_ready[0]) acc.push_back(k);
                if (out_valid[0]) nv++;
                @(posedge clk); #1;
            end
            in_valid[0] = 1'b0;
            total++;
            if (acc.size() != ((w != 0) ? 3 : 4)) begin
                bad++; $display("FAIL b2b%0d_accepts got %0d want %0d", w, acc.size(),
                                (w != 0) ? 3 : 4);
            end
            total++;
            if (acc.size() < 2 || acc[1] - acc[0] != per) begin
                bad++; $display("FAIL b2b%0d_period got %0d want %0d", w,
                                (acc.size() < 2) ? -1 : acc[1] - acc[0], per);
            end
            total++;
            if (nv != ((w != 0) ? 2 : 3)) begin
                bad++; $display("FAIL b2b%0d_valid_cycles got %0d want %0d", w, nv,
                                (w != 0) ? 2 : 3);
            end
            repeat (8) @(posedge clk);
            #1;
            total++;
            if (out_sum[0] !== 32'h3 || in_ready[0] !== 1'b1) begin
                bad++; $display("FAIL b2b%0d_drain got sum %h ready %b want 3 1", w,
                                out_sum[0], in_ready[0]);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready = 1'b0;
        run_op(0, 32'h0000_8000, 32'h0000_0001, 1'b1, 1'b0, lat);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                in_a = 32'h0000_FFFF; in_b = 32'h0000_0001; in_sub = 1'b0; in_wide = 1'b0;
                in_valid[0] = 1'b1;
            end
            total++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d_handshake got valid %b ready %b want 1 0", k,
                                out_valid[0], in_ready[0]);
            end
            total++;
            if ({out_sum[0], out_carry[0], out_ovf[0], out_zero[0]}
                !== {32'h0000_7FFF, 1'b1, 1'b1, 1'b0}) begin
                bad++; $display("FAIL bp_hold%0d_result got %h c%b o%b z%b want 7fff c1 o1 z0",
                                k, out_sum[0], out_carry[0], out_ovf[0], out_zero[0]);
            end
            @(posedge clk); #1;
            in_valid[0] = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            bad++; $display("FAIL bp_release got valid %b ready %b want 0 1",
                            out_valid[0], in_ready[0]);
        end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            bad++; $display("FAIL bp_no_queue got valid %b ready %b want 0 1",
                            out_valid[0], in_ready[0]);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        out_ready = 1'b0;
        in_a = 32'h1111_2222; in_b = 32'h3333_4444; in_sub = 1'b0; in_wide = 1'b1;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (add_a[0] !== 16'h1111 || add_b[0] !== 16'h3333) begin
            bad++; $display("FAIL rmid_hi_adder got a %h b %h want 1111 3333",
                            add_a[0], add_b[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid[0], add_a[0], add_b[0], add_cin[0]} !== 34'h0) begin
            bad++; $display("FAIL rmid_async got valid %b a %h b %h cin %b want 0",
                            out_valid[0], add_a[0], add_b[0], add_cin[0]);
        end
        total++;
        if (in_ready[0] !== 1'b1 || out_sum[0] !== 32'h0) begin
            bad++; $display("FAIL rmid_idle got ready %b sum %h want 1 0",
                            in_ready[0], out_sum[0]);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_op(0, 32'h0000_24D7, 32'h0000_0414, 1'b0, 1'b0, lat);
        total++;
        if (lat != 3 || out_sum[0] !== 32'h0000_28EB) begin
            bad++; $display("FAIL rmid_next_op got lat %0d sum %h want 3 28eb", lat, out_sum[0]);
        end
        ack();
    endtask

    task automatic test_latency;
        int lat;
        int s;
        out_ready = 1'b1;
        for (int idx = 1; idx < 3; idx++) begin
            s = (idx == 1) ? 1 : 15;
            run_op(idx, 32'h0000_7000, 32'h0000_1001, 1'b0, 1'b0, lat);
            total++;
            if (lat != s + 1) begin
                bad++; $display("FAIL lat_s%0d_narrow got %0d want %0d", s, lat, s + 1);
            end
            total++;
            if ($isunknown(out_sum[idx]) || out_sum[idx] !== 32'h0000_8001 ||
                {out_carry[idx], out_ovf[idx], out_zero[idx]} !== 3'b010) begin
                bad++; $display("FAIL lat_s%0d_narrow_result got %h c%b o%b z%b want 8001 c0 o1 z0",
                                s, out_sum[idx], out_carry[idx], out_ovf[idx], out_zero[idx]);
            end
            @(posedge clk); #1;
            total++;
            if (out_valid[idx] !== 1'b0 || in_ready[idx] !== 1'b1) begin
                bad++; $display("FAIL lat_s%0d_one_cycle got valid %b ready %b want 0 1", s,
                                out_valid[idx], in_ready[idx]);
            end
            run_op(idx, 32'h89AB_CDEF, 32'h0123_4567, 1'b1, 1'b1, lat);
            total++;
            if (lat != 2 * s + 1) begin
                bad++; $display("FAIL lat_s%0d_wide got %0d want %0d", s, lat, 2 * s + 1);
            end
            total++;
            if ($isunknown(out_sum[idx]) || out_sum[idx] !== 32'h8888_8888 ||
                {out_carry[idx], out_ovf[idx], out_zero[idx]} !== 3'b100) begin
                bad++; $display("FAIL lat_s%0d_wide_result got %h c%b o%b z%b want 88888888 c1 o0 z0",
                                s, out_sum[idx], out_carry[idx], out_ovf[idx], out_zero[idx]);
            end
            @(posedge clk); #1;
            total++;
            if (out_valid[idx] !== 1'b0 || in_ready[idx] !== 1'b1) begin
                bad++; $display("FAIL lat_s%0d_wide_one_cycle got valid %b ready %b want 0 1", s,
                                out_valid[idx], in_ready[idx]);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = '0; in_a = '0; in_b = '0; in_sub = 1'b0; in_wide = 1'b0; out_ready = 1'b0;
        test_reset;
        test_narrow;
        test_wide;
        test_back_to_back;
        test_backpressure;
        test_reset_mid;
        test_latency;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
